// File: rtl/adc_wr_pkg.sv
// rtl/adc_wr_pkg.sv - shared FSM states and lane constants for the ADC sample writer
package adc_wr_pkg;

   typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} wr_state_t;

   localparam int         LANE_W  = 16;
   localparam logic [3:0] BE_FULL = 4'b1111;
   localparam logic [3:0] BE_LOW  = 4'b0011;

endpackage

// File: rtl/adc_wr_fifo.sv
// rtl/adc_wr_fifo.sv - synchronous sample FIFO with push/pop, full/empty and fill count
module adc_wr_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/adc_sample_writer.sv
// rtl/adc_sample_writer.sv - Avalon-MM write master packing ADC samples into a memory window
// Optional two-samples-per-word packing is enabled by defining SAMPLE_PACK_EN.
module adc_sample_writer
   import adc_wr_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int SAMPLE_W   = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ctrl_start,
   input  logic                ctrl_stop,
   input  logic                ctrl_circular,
   input  logic [ADDR_W-1:0]   ctrl_base,
   input  logic [15:0]         ctrl_words,
   input  logic                snk_valid,
   input  logic [SAMPLE_W-1:0] snk_data,
   output logic                snk_ready,
   output logic [ADDR_W-1:0]   m_address,
   output logic                m_write,
   output logic [31:0]         m_writedata,
   output logic [3:0]          m_byteenable,
   input  logic                m_waitrequest,
   output logic                stat_busy,
   output logic                stat_done,
   output logic                stat_overflow,
   output logic [15:0]         stat_wr_ptr,
   output logic                irq
);
`ifdef SAMPLE_PACK_EN
   localparam bit PACK_EN = 1'b1;
`else
   localparam bit PACK_EN = 1'b0;
`endif
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   wr_state_t             state_q, state_d;
   logic [ADDR_W-1:0]     base_q;
   logic [15:0]           words_q;
   logic [15:0]           wr_ptr_q;
   logic                  circ_q, stop_q, lane_q, done_q, ovf_q;
   logic [2*LANE_W-1:0]   word_q;
   logic [3:0]            be_q;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0]   fifo_data;
   logic [CW-1:0]         fifo_count;
   logic                  busy, start_ok, accept, last_word, drained;

   assign busy      = (state_q == PACK) || (state_q == WRITE);
   assign start_ok  = ctrl_start && ((state_q == IDLE) || (state_q == DONE));
   assign snk_ready = busy & ~fifo_full & ~stop_q;
   assign fifo_push = snk_valid & snk_ready;
   assign accept    = (state_q == WRITE) & ~m_waitrequest;
   assign last_word = ((wr_ptr_q + 16'd1) == words_q);
   // Once stop is latched no more samples enter, so an empty FIFO is final.
   assign drained   = stop_q & (fifo_count == '0);

   adc_wr_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (start_ok),
      .push      (fifo_push),
      .push_data (snk_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE, DONE: state_d = start_ok ? PACK : IDLE;
         PACK: begin
            if (drained) begin
               state_d = lane_q ? WRITE : DONE;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (lane_q || !PACK_EN) state_d = WRITE;
            end
         end
         WRITE: if (accept) state_d = (last_word && !circ_q) ? DONE : PACK;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q   <= '0;
         words_q  <= '0;
         wr_ptr_q <= '0;
         circ_q   <= 1'b0;
         stop_q   <= 1'b0;
         lane_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         word_q   <= '0;
         be_q     <= '0;
      end else if (start_ok) begin
         base_q   <= ctrl_base & ~ADDR_W'(3);
         words_q  <= (ctrl_words == 16'd0) ? 16'd1 : ctrl_words;
         circ_q   <= ctrl_circular;
         wr_ptr_q <= '0;
         stop_q   <= 1'b0;
         lane_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (ctrl_stop && busy)                 stop_q <= 1'b1;
         if (busy && snk_valid && !snk_ready)   ovf_q  <= 1'b1;
         if (state_d == DONE)                   done_q <= 1'b1;
         if (fifo_pop) begin
            if (PACK_EN && lane_q) begin
               word_q[2*LANE_W-1:LANE_W] <= LANE_W'(fifo_data);
               be_q   <= BE_FULL;
               lane_q <= 1'b0;
            end else begin
               word_q <= {{LANE_W{1'b0}}, LANE_W'(fifo_data)};
               be_q   <= BE_FULL;
               lane_q <= PACK_EN;
            end
         end else if ((state_q == PACK) && drained && lane_q) begin
            // Odd sample left at stop: upper lane already zero, enable low lane only.
            be_q   <= BE_LOW;
            lane_q <= 1'b0;
         end
         if (accept) wr_ptr_q <= (last_word && circ_q) ? 16'd0 : wr_ptr_q + 16'd1;
      end
   end

   assign m_address     = base_q + ADDR_W'({wr_ptr_q, 2'b00});
   assign m_write       = (state_q == WRITE);
   assign m_writedata   = word_q;
   assign m_byteenable  = be_q;
   assign stat_busy     = busy;
   assign stat_done     = done_q;
   assign stat_overflow = ovf_q;
   assign stat_wr_ptr   = wr_ptr_q;
   assign irq           = done_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// tb/tb_adc_sample_writer.sv - directed bench for adc_sample_writer (SAMPLE_PACK_EN aware)
module tb_adc_sample_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ctrl_start = 1'b0, ctrl_stop = 1'b0, ctrl_circular = 1'b0;
   logic [17:0] ctrl_base = '0;
   logic [15:0] ctrl_words = '0;
   logic        snk_valid = 1'b0;
   logic [11:0] snk_data = '0;
   logic        snk_ready;
   logic [17:0] m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest = 1'b0;
   logic        stat_busy, stat_done, stat_overflow, irq;
   logic [15:0] stat_wr_ptr;

   int checks = 0;
   int errors = 0;

   logic [17:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [3:0]  wr_be_q[$];
   logic [15:0] ptr_q[$];
   logic        acc_pend = 1'b0;

   always #5 clk = ~clk;

   adc_sample_writer dut (
      .clk(clk), .reset_n(reset_n),
      .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_circular(ctrl_circular),
      .ctrl_base(ctrl_base), .ctrl_words(ctrl_words),
      .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
      .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
      .stat_busy(stat_busy), .stat_done(stat_done), .stat_overflow(stat_overflow),
      .stat_wr_ptr(stat_wr_ptr), .irq(irq)
   );

   // Record every accepted write, and the write pointer the cycle after it.
   always @(negedge clk) begin
      if (acc_pend) ptr_q.push_back(stat_wr_ptr);
      if (reset_n && m_write && !m_waitrequest) begin
         wr_addr_q.push_back(m_address);
         wr_data_q.push_back(m_writedata);
         wr_be_q.push_back(m_byteenable);
      end
      acc_pend <= reset_n && m_write && !m_waitrequest;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_circular = 1'b0;
      ctrl_base = '0; ctrl_words = '0; snk_valid = 1'b0; snk_data = '0; m_waitrequest = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic start(input logic [17:0] base, input logic [15:0] words, input logic circ);
      wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); ptr_q.delete();
      ctrl_base = base; ctrl_words = words; ctrl_circular = circ; ctrl_start = 1'b1;
      tick();
      ctrl_start = 1'b0;
   endtask

   task automatic send_sample(input logic [11:0] d);
      int n = 0;
      snk_valid = 1'b1; snk_data = d;
      @(negedge clk);
      while (!snk_ready && n < 100) begin n++; @(negedge clk); end
      tick();
      snk_valid = 1'b0;
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL send_timeout: sample %h never accepted", d);
      end
   endtask

   task automatic stop_pulse();
      ctrl_stop = 1'b1;
      tick();
      ctrl_stop = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      @(negedge clk);
      while (!stat_done && n < 500) begin n++; @(negedge clk); end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout: stat_done=%b required 1", name, stat_done);
      end
      tick();
   endtask

   task automatic wait_write(input string name);
      int n = 0;
      @(negedge clk);
      while (!m_write && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL %s_write_timeout: m_write=%b required 1", name, m_write);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({m_write, stat_busy, stat_done, stat_overflow, irq, snk_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000",
                  {m_write, stat_busy, stat_done, stat_overflow, irq, snk_ready});
      end
      checks++;
      if (stat_wr_ptr !== 16'h0) begin errors++; $display("FAIL reset_wr_ptr: got %h required 0", stat_wr_ptr); end
      checks++;
      if (m_address !== 18'h0) begin errors++; $display("FAIL reset_address: got %h required 0", m_address); end
      checks++;
      if ({m_writedata, m_byteenable} !== 36'h0) begin
         errors++; $display("FAIL reset_data_be: got %h/%h required 0/0", m_writedata, m_byteenable);
      end
      snk_valid = 1'b1; snk_data = 12'h5A5;
      @(negedge clk);
      checks++;
      if (snk_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b required 0", snk_ready); end
      repeat (2) tick();
      snk_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (stat_overflow !== 1'b0) begin errors++; $display("FAIL idle_overflow: got %b required 0", stat_overflow); end
   endtask

   task automatic test_basic();
      logic [17:0] ea[$];
      logic [31:0] ed[$];
      logic [3:0]  eb[$];
      ea = {18'h100, 18'h104};
      eb = {4'hF, 4'hF};
`ifdef SAMPLE_PACK_EN
      ed = {32'h00020001, 32'h00040003};
`else
      ed = {32'h00000001, 32'h00000002};
`endif
      start(18'h100, 16'd2, 1'b0);
      for (int i = 1; i <= 4; i++) send_sample(12'(i));
      wait_done("basic");
      checks++;
      if (wr_data_q.size() != ed.size()) begin
         errors++; $display("FAIL basic_count: got %0d required %0d", wr_data_q.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < wr_data_q.size(); i++) begin
         checks++;
         if ({wr_addr_q[i], wr_data_q[i], wr_be_q[i]} !== {ea[i], ed[i], eb[i]}) begin
            errors++;
            $display("FAIL basic_write%0d: got %h/%h/%h required %h/%h/%h", i,
                     wr_addr_q[i], wr_data_q[i], wr_be_q[i], ea[i], ed[i], eb[i]);
         end
      end
      checks++;
      if ({stat_done, irq, stat_busy} !== 3'b110) begin
         errors++; $display("FAIL basic_status: done/irq/busy got %b required 110", {stat_done, irq, stat_busy});
      end
      checks++;
      if (stat_wr_ptr !== 16'd2) begin errors++; $display("FAIL basic_wr_ptr: got %0d required 2", stat_wr_ptr); end
   endtask

   task automatic test_latency();
      logic [31:0] ed;
      start(18'h040, 16'd1, 1'b0);
`ifdef SAMPLE_PACK_EN
      ed = 32'h00BB00AA;
      send_sample(12'h0AA);
      @(negedge clk); @(negedge clk);
      checks++;
      if (m_write !== 1'b0) begin errors++; $display("FAIL latency_half_word: m_write got %b required 0", m_write); end
      send_sample(12'h0BB);
`else
      ed = 32'h000000AA;
      send_sample(12'h0AA);
`endif
      @(negedge clk);
      checks++;
      if (m_write !== 1'b0) begin errors++; $display("FAIL latency_cycle1: m_write got %b required 0", m_write); end
      @(negedge clk);
      checks++;
      if (m_write !== 1'b1) begin errors++; $display("FAIL latency_cycle2: m_write got %b required 1", m_write); end
      wait_done("latency");
      checks++;
      if (wr_data_q.size() != 1 || wr_data_q[0] !== ed || wr_addr_q[0] !== 18'h040) begin
         errors++; $display("FAIL latency_write: got %0d writes, first %h required %h", wr_data_q.size(),
                            (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, ed);
      end
   endtask

   task automatic test_stall();
      logic [31:0] ed;
      m_waitrequest = 1'b1;
      start(18'h200, 16'd1, 1'b0);
`ifdef SAMPLE_PACK_EN
      ed = 32'h01230ABC;
      send_sample(12'hABC);
      send_sample(12'h123);
`else
      ed = 32'h00000ABC;
      send_sample(12'hABC);
`endif
      wait_write("stall");
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin
            tick();
            if (k == 4) m_waitrequest = 1'b0;
            @(negedge clk);
         end
         checks++;
         if ({m_write, m_address, m_writedata, m_byteenable} !== {1'b1, 18'h200, ed, 4'hF}) begin
            errors++;
            $display("FAIL stall_hold%0d: got %b/%h/%h/%h required 1/00200/%h/f", k,
                     m_write, m_address, m_writedata, m_byteenable, ed);
         end
      end
      wait_done("stall");
      checks++;
      if (wr_data_q.size() != 1) begin errors++; $display("FAIL stall_accepts: got %0d required 1", wr_data_q.size()); end
   endtask

   task automatic test_circular();
      logic [17:0] ea[$];
      logic [31:0] ed[$];
      logic [15:0] ep[$];
`ifdef SAMPLE_PACK_EN
      ea = {18'h100, 18'h104, 18'h100};
      ed = {32'h00120011, 32'h00140013, 32'h00160015};
      ep = {16'd1, 16'd0, 16'd1};
`else
      ea = {18'h100, 18'h104, 18'h100, 18'h104, 18'h100, 18'h104};
      ed = {32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
      ep = {16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
`endif
      start(18'h100, 16'd2, 1'b1);
      for (int i = 0; i < 6; i++) send_sample(12'(32'h11 + i));
      stop_pulse();
      wait_done("circular");
      checks++;
      if (wr_data_q.size() != ed.size() || ptr_q.size() != ep.size()) begin
         errors++; $display("FAIL circ_count: got %0d/%0d required %0d", wr_data_q.size(), ptr_q.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < wr_data_q.size() && i < ptr_q.size(); i++) begin
         checks++;
         if ({wr_addr_q[i], wr_data_q[i], wr_be_q[i], ptr_q[i]} !== {ea[i], ed[i], 4'hF, ep[i]}) begin
            errors++;
            $display("FAIL circ_write%0d: got %h/%h/%h ptr %0d required %h/%h/f ptr %0d", i,
                     wr_addr_q[i], wr_data_q[i], wr_be_q[i], ptr_q[i], ea[i], ed[i], ep[i]);
         end
      end
      checks++;
      if ({stat_done, stat_overflow} !== 2'b10) begin
         errors++; $display("FAIL circ_status: done/ovf got %b required 10", {stat_done, stat_overflow});
      end
   endtask

   task automatic test_overflow();
      logic [31:0] ed[$];
      int stalls = 0;
      int exp_stalls;
`ifdef SAMPLE_PACK_EN
      ed = {32'h01010100, 32'h01030102, 32'h01050104, 32'h01070106, 32'h01090108};
      exp_stalls = 4;
`else
      ed = {32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h108};
      exp_stalls = 5;
`endif
      m_waitrequest = 1'b1;
      start(18'h000, 16'd16, 1'b0);
      for (int i = 0; i < 14; i++) begin
         snk_valid = 1'b1; snk_data = 12'(32'h100 + i);
         @(negedge clk);
         if (!snk_ready) stalls++;
         tick();
      end
      snk_valid = 1'b0;
      stop_pulse();
      repeat (6) tick();
      m_waitrequest = 1'b0;
      wait_done("overflow");
      checks++;
      if (stat_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", stat_overflow); end
      checks++;
      if (stalls != exp_stalls) begin errors++; $display("FAIL ovf_ready_low: got %0d required %0d", stalls, exp_stalls); end
      checks++;
      if (wr_data_q.size() != ed.size()) begin
         errors++; $display("FAIL ovf_count: got %0d required %0d", wr_data_q.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < wr_data_q.size(); i++) begin
         checks++;
         if ({wr_addr_q[i], wr_data_q[i]} !== {18'(4 * i), ed[i]}) begin
            errors++;
            $display("FAIL ovf_write%0d: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], 18'(4 * i), ed[i]);
         end
      end
      checks++;
      if (stat_wr_ptr !== 16'(ed.size())) begin
         errors++; $display("FAIL ovf_wr_ptr: got %0d required %0d", stat_wr_ptr, ed.size());
      end
   endtask

   task automatic test_flush();
      logic [17:0] ea[$];
      logic [31:0] ed[$];
      logic [3:0]  eb[$];
`ifdef SAMPLE_PACK_EN
      ea = {18'h300, 18'h304};
      ed = {32'h00020001, 32'h00000003};
      eb = {4'hF, 4'h3};
`else
      ea = {18'h300, 18'h304, 18'h308};
      ed = {32'h1, 32'h2, 32'h3};
      eb = {4'hF, 4'hF, 4'hF};
`endif
      start(18'h300, 16'd4, 1'b0);
      for (int i = 1; i <= 3; i++) send_sample(12'(i));
      stop_pulse();
      wait_done("flush");
      checks++;
      if (wr_data_q.size() != ed.size()) begin
         errors++; $display("FAIL flush_count: got %0d required %0d", wr_data_q.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < wr_data_q.size(); i++) begin
         checks++;
         if ({wr_addr_q[i], wr_data_q[i], wr_be_q[i]} !== {ea[i], ed[i], eb[i]}) begin
            errors++;
            $display("FAIL flush_write%0d: got %h/%h/%h required %h/%h/%h", i,
                     wr_addr_q[i], wr_data_q[i], wr_be_q[i], ea[i], ed[i], eb[i]);
         end
      end
      checks++;
      if (stat_wr_ptr !== 16'(ed.size())) begin
         errors++; $display("FAIL flush_wr_ptr: got %0d required %0d", stat_wr_ptr, ed.size());
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] ed[$];
`ifdef SAMPLE_PACK_EN
      ed = {32'h00220021, 32'h00240023};
`else
      ed = {32'h21, 32'h22};
`endif
      m_waitrequest = 1'b1;
      start(18'h100, 16'd2, 1'b0);
      send_sample(12'h0AA);
      send_sample(12'h0BB);
      wait_write("midreset");
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({m_write, stat_busy, stat_wr_ptr} !== 18'h0) begin
         errors++; $display("FAIL midreset_async: write/busy/ptr got %b/%b/%h required 0/0/0",
                            m_write, stat_busy, stat_wr_ptr);
      end
      do_reset();
      start(18'h100, 16'd2, 1'b0);
      for (int i = 0; i < 4; i++) send_sample(12'(32'h21 + i));
      wait_done("midreset");
      checks++;
      if (wr_data_q.size() != 2) begin errors++; $display("FAIL midreset_count: got %0d required 2", wr_data_q.size()); end
      for (int i = 0; i < 2 && i < wr_data_q.size(); i++) begin
         checks++;
         if ({wr_addr_q[i], wr_data_q[i]} !== {18'(18'h100 + 4 * i), ed[i]}) begin
            errors++;
            $display("FAIL midreset_write%0d: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i],
                     18'(18'h100 + 4 * i), ed[i]);
         end
      end
      checks++;
      if (stat_wr_ptr !== 16'd2) begin errors++; $display("FAIL midreset_wr_ptr: got %0d required 2", stat_wr_ptr); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_stall();
      test_circular();
      test_overflow();
      test_flush();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
